crc_engine: RTL and testbench

- Parametrised serial CRC engine for the bit-serial packet path. Supersedes the fixed CRC5/CRC16 appender.
- Two runtime-selectable polynomials, A and B, each with its own width.
- Generate mode: passes packet bits through, then appends the complemented CRC MSB-first with stall handshaking.
- Check mode: passes bits through, then compares the final register against the polynomial's good-packet residual and reports pass/fail.

---
 rtl/crc_engine.sv | 192 +++++++++++++++++++
 tb/tb_crc_engine.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// crc_engine: parametrised bit-serial CRC engine with two runtime-selectable polynomials.
//
// Generate mode passes the packet body through unchanged and then appends the complemented
// CRC, MSB first. Check mode passes the body through and compares the final register against
// the good-packet residual of the selected polynomial.
//
// Ports:
//   clk        clock
//   rst_L      asynchronous active-low reset
//   start      one-cycle pulse; arms a new packet (aborts any packet in flight),
//              samples crc_sel and mode_chk
//   crc_sel    0 = polynomial A, 1 = polynomial B
//   mode_chk   0 = generate/append, 1 = check
//   in_bit     serial data bit
//   in_valid   high while the packet body is supplied
//   pause_out  downstream stall
//   pause_in   stall to upstream
//   out_bit    serial output bit
//   sending    out_bit is valid
//   chk_done   one-cycle pulse; check result valid
//   chk_ok     check result; holds until the next start
module crc_engine #(
    parameter int unsigned       MAX_W  = 16,
    parameter int unsigned       W_A    = 5,
    parameter logic [MAX_W-1:0]  POLY_A = 'h0005,
    parameter logic [MAX_W-1:0]  RES_A  = 'h000C,
    parameter int unsigned       W_B    = 16,
    parameter logic [MAX_W-1:0]  POLY_B = 'h8005,
    parameter logic [MAX_W-1:0]  RES_B  = 'h800D
) (
    input  logic clk,
    input  logic rst_L,
    input  logic start,
    input  logic crc_sel,
    input  logic mode_chk,
    input  logic in_bit,
    input  logic in_valid,
    input  logic pause_out,
    output logic pause_in,
    output logic out_bit,
    output logic sending,
    output logic chk_done,
    output logic chk_ok
);

    localparam int unsigned      CntW  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [MAX_W-1:0] Ones  = '1;
    localparam logic [MAX_W-1:0] MaskA = ~(Ones << W_A);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCalc,
        StAppend
    } state_e;

    state_e            state_q, state_d;
    logic [MAX_W-1:0]  crc_q, crc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              sel_q, sel_d;
    logic              mode_q, mode_d;
    logic              chk_ok_q, chk_ok_d;

    int unsigned       w_act;
    logic [MAX_W-1:0]  mask;
    logic [MAX_W-1:0]  poly;
    logic [MAX_W-1:0]  res;
    logic [CntW-1:0]   top_idx;
    logic [CntW-1:0]   app_idx;
    logic              fb;
    logic [MAX_W-1:0]  crc_step;
    logic              consume;

    // Datapath helpers for the latched polynomial.
    always_comb begin
        w_act    = sel_q ? W_B : W_A;
        mask     = ~(Ones << w_act);
        poly     = sel_q ? POLY_B : POLY_A;
        res      = sel_q ? RES_B : RES_A;
        top_idx  = CntW'(w_act - 1);
        app_idx  = top_idx - count_q;
        fb       = in_bit ^ crc_q[top_idx];
        crc_step = ((crc_q << 1) ^ (fb ? poly : '0)) & mask;
        consume  = ((state_q == StArmed) || (state_q == StCalc)) && in_valid && !pause_out;
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        count_d  = count_q;
        sel_d    = sel_q;
        mode_d   = mode_q;
        chk_ok_d = chk_ok_q;
        pause_in = 1'b0;
        out_bit  = 1'b0;
        sending  = 1'b0;
        chk_done = 1'b0;
        chk_ok   = chk_ok_q;

        if (start) begin
            // Start wins in every state, so an in-flight packet is dropped silently.
            state_d  = StArmed;
            sel_d    = crc_sel;
            mode_d   = mode_chk;
            crc_d    = ~(Ones << (crc_sel ? W_B : W_A));
            count_d  = '0;
            chk_ok_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end

                StArmed: begin
                    out_bit  = in_bit;
                    sending  = in_valid;
                    pause_in = pause_out;
                    if (consume) begin
                        crc_d   = crc_step;
                        state_d = StCalc;
                    end
                end

                StCalc: begin
                    out_bit  = in_bit;
                    sending  = in_valid;
                    pause_in = pause_out;
                    if (consume) begin
                        crc_d = crc_step;
                    end else if (!in_valid && !mode_q) begin
                        // Body over in generate mode: the first CRC bit goes out in this
                        // cycle, so APPEND continues from bit index 1.
                        out_bit  = ~crc_q[top_idx];
                        sending  = 1'b1;
                        pause_in = 1'b1;
                        if (!pause_out) begin
                            if (w_act == 1) begin
                                state_d = StIdle;
                                crc_d   = mask;
                            end else begin
                                state_d = StAppend;
                                count_d = CntW'(1);
                            end
                        end
                    end else if (!in_valid && !pause_out) begin
                        chk_done = 1'b1;
                        chk_ok_d = (crc_q == res);
                        chk_ok   = chk_ok_d;
                        state_d  = StIdle;
                    end
                end

                StAppend: begin
                    out_bit  = ~crc_q[app_idx];
                    sending  = 1'b1;
                    pause_in = 1'b1;
                    if (!pause_out) begin
                        if (count_q == top_idx) begin
                            state_d = StIdle;
                            crc_d   = mask;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CntW'(1);
                        end
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q  <= StIdle;
            crc_q    <= MaskA;
            count_q  <= '0;
            sel_q    <= 1'b0;
            mode_q   <= 1'b0;
            chk_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            count_q  <= count_d;
            sel_q    <= sel_d;
            mode_q   <= mode_d;
            chk_ok_q <= chk_ok_d;
        end
    end

endmodule

// File: tb/tb_crc_engine.sv
// tb_crc_engine: directed, self-checking bench for crc_engine.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_crc_engine;

    logic clk = 1'b0;
    logic rst_L, start, crc_sel, mode_chk, in_bit, in_valid, pause_out;
    logic pause_in, out_bit, sending, chk_done, chk_ok;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crc_engine dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .start     (start),
        .crc_sel   (crc_sel),
        .mode_chk  (mode_chk),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .pause_out (pause_out),
        .pause_in  (pause_in),
        .out_bit   (out_bit),
        .sending   (sending),
        .chk_done  (chk_done),
        .chk_ok    (chk_ok)
    );

    typedef struct {
        logic st, sel, mode, b, v, p;
        logic e_out, e_send, e_pin, e_done;
    } vec_t;

    vec_t tbl[18];

    // USB token addr=0x15, endp=0xE; bit i is the i-th bit on the wire.
    logic [10:0] tok;
    // CRC5 field 0x17 as transmitted (bit k = k-th appended bit): 1,0,1,1,1.
    logic [4:0]  c5_tx;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic b, input logic v, input logic p);
        start     = st;
        in_bit    = b;
        in_valid  = v;
        pause_out = p;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Reflected (LSB-first) formulation of the same CRC; result bit k is the k-th
    // transmitted CRC bit.
    function automatic logic [15:0] ref_crc(input logic [47:0] b, input int n, input int w,
                                            input logic [15:0] rpoly);
        logic [15:0] m, c;
        m = 16'hFFFF >> (16 - w);
        c = m;
        for (int i = 0; i < n; i++) begin
            if (c[0] ^ b[i]) c = (c >> 1) ^ rpoly;
            else             c = c >> 1;
        end
        return ~c & m;
    endfunction

    function automatic logic [15:0] rpoly_of(input logic sel);
        return sel ? 16'hA001 : 16'h0014;
    endfunction

    // Generate-mode packet with optional stalls at body bit sb (sbl cycles) and
    // append bit sa (sal cycles).
    task automatic run_gen(input logic sel, input logic [47:0] body, input int n, input int w,
                           input int sb, input int sbl, input int sa, input int sal,
                           input string tag);
        logic [15:0] crc;
        crc      = ref_crc(body, n, w, rpoly_of(sel));
        crc_sel  = sel;
        mode_chk = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, " start sending"}, sending, 1'b0);
        chk({tag, " start chk_done"}, chk_done, 1'b0);
        adv();
        // Changing the selectors after start must have no effect.
        crc_sel  = ~sel;
        mode_chk = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " armed sending"}, sending, 1'b0);
        adv();
        for (int i = 0; i < n; i++) begin
            if (i == sb) begin
                for (int j = 0; j < sbl; j++) begin
                    drive(1'b0, body[i], 1'b1, 1'b1);
                    chk($sformatf("%s body stall %0d pause_in", tag, j), pause_in, 1'b1);
                    chk($sformatf("%s body stall %0d out_bit", tag, j), out_bit, body[i]);
                    adv();
                end
            end
            drive(1'b0, body[i], 1'b1, 1'b0);
            chk($sformatf("%s body %0d out_bit", tag, i), out_bit, body[i]);
            chk($sformatf("%s body %0d sending", tag, i), sending, 1'b1);
            chk($sformatf("%s body %0d pause_in", tag, i), pause_in, 1'b0);
            adv();
        end
        for (int k = 0; k < w; k++) begin
            if (k == sa) begin
                for (int j = 0; j < sal; j++) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b1);
                    chk($sformatf("%s app stall %0d out_bit", tag, j), out_bit, crc[k]);
                    chk($sformatf("%s app stall %0d sending", tag, j), sending, 1'b1);
                    adv();
                end
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("%s crc %0d out_bit", tag, k), out_bit, crc[k]);
            chk($sformatf("%s crc %0d pause_in", tag, k), pause_in, 1'b1);
            chk($sformatf("%s crc %0d sending", tag, k), sending, 1'b1);
            adv();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " after append sending"}, sending, 1'b0);
        chk({tag, " after append pause_in"}, pause_in, 1'b0);
        adv();
    endtask

    task automatic run_check(input logic sel, input logic [47:0] s, input int n,
                             input logic exp_ok, input string tag);
        crc_sel  = sel;
        mode_chk = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv();
        crc_sel  = ~sel;
        mode_chk = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, s[i], 1'b1, 1'b0);
            chk($sformatf("%s bit %0d chk_done", tag, i), chk_done, 1'b0);
            chk($sformatf("%s bit %0d out_bit", tag, i), out_bit, s[i]);
            adv();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " eop chk_done"}, chk_done, 1'b1);
        chk({tag, " eop chk_ok"}, chk_ok, exp_ok);
        chk({tag, " eop sending"}, sending, 1'b0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, " post chk_done"}, chk_done, 1'b0);
        chk({tag, " post chk_ok hold"}, chk_ok, exp_ok);
        adv();
    endtask

    initial begin
        logic [47:0] s5, body32, s16;
        logic [15:0] c16;

        tok   = {4'hE, 7'h15};
        c5_tx = 5'b11101;

        rst_L = 1'b0; start = 1'b0; crc_sel = 1'b0; mode_chk = 1'b0;
        in_bit = 1'b0; in_valid = 1'b0; pause_out = 1'b0;
        #12;
        chk("reset pause_in", pause_in, 1'b0);
        chk("reset out_bit", out_bit, 1'b0);
        chk("reset sending", sending, 1'b0);
        chk("reset chk_done", chk_done, 1'b0);
        chk("reset chk_ok", chk_ok, 1'b0);
        rst_L = 1'b1;
        adv();

        // 1: generate CRC5 on the USB token, table driven.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++)
            tbl[1 + i] = '{1'b0, 1'b0, 1'b0, tok[i], 1'b1, 1'b0, tok[i], 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 5; k++)
            tbl[12 + k] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c5_tx[k], 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 18; i++) begin
            crc_sel  = tbl[i].sel;
            mode_chk = tbl[i].mode;
            drive(tbl[i].st, tbl[i].b, tbl[i].v, tbl[i].p);
            chk($sformatf("t1[%0d] out_bit", i), out_bit, tbl[i].e_out);
            chk($sformatf("t1[%0d] sending", i), sending, tbl[i].e_send);
            chk($sformatf("t1[%0d] pause_in", i), pause_in, tbl[i].e_pin);
            chk($sformatf("t1[%0d] chk_done", i), chk_done, tbl[i].e_done);
            adv();
        end

        // 2: check the 16-bit token stream, then with bit 3 flipped.
        s5 = 48'(tok) | (48'(c5_tx) << 11);
        run_check(1'b0, s5, 16, 1'b1, "t2 good");
        run_check(1'b0, s5 ^ 48'h8, 16, 1'b0, "t2 flip3");

        // 4: stalls during body bit 4 and append bit 2.
        run_gen(1'b0, 48'(tok), 11, 5, 4, 3, 2, 2, "t4");

        // 5: abort mid-body (generate, then check), then a fresh packet.
        crc_sel = 1'b0; mode_chk = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, tok[i], 1'b1, 1'b0);
            adv();
        end
        run_gen(1'b0, 48'(tok), 11, 5, -1, 0, -1, 0, "t5 gen-abort");
        crc_sel = 1'b0; mode_chk = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, s5[i], 1'b1, 1'b0);
            adv();
        end
        run_gen(1'b0, 48'(tok), 11, 5, -1, 0, -1, 0, "t5 chk-abort");

        // 3: CRC16 generate on 0x03020100, check, and single-bit flips.
        body32 = 48'h0000_0302_0100;
        run_gen(1'b1, body32, 32, 16, -1, 0, -1, 0, "t3 gen");
        c16 = ref_crc(body32, 32, 16, rpoly_of(1'b1));
        s16 = body32 | (48'(c16) << 32);
        run_check(1'b1, s16, 48, 1'b1, "t3 good");
        run_check(1'b1, s16 ^ (48'd1 << 0), 48, 1'b0, "t3 flip0");
        run_check(1'b1, s16 ^ (48'd1 << 19), 48, 1'b0, "t3 flip19");
        run_check(1'b1, s16 ^ (48'd1 << 33), 48, 1'b0, "t3 flip33");
        run_check(1'b1, s16 ^ (48'd1 << 47), 48, 1'b0, "t3 flip47");

        // 6: asynchronous reset in the middle of the append phase.
        run_check(1'b0, s5, 16, 1'b1, "t6 pre");
        crc_sel = 1'b0; mode_chk = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, tok[i], 1'b1, 1'b0);
            adv();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        adv();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6 mid-append sending", sending, 1'b1);
        rst_L = 1'b0;
        #1;
        chk("t6 rst pause_in", pause_in, 1'b0);
        chk("t6 rst out_bit", out_bit, 1'b0);
        chk("t6 rst sending", sending, 1'b0);
        chk("t6 rst chk_done", chk_done, 1'b0);
        chk("t6 rst chk_ok", chk_ok, 1'b0);
        @(posedge clk);
        #2;
        rst_L = 1'b1;
        adv();
        run_gen(1'b0, 48'(tok), 11, 5, -1, 0, -1, 0, "t6 after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
